sram_pixel_reader: RTL and testbench
====================================

SRAM_PIXEL_READER -- requirements
Module: sram_pixel_reader

Interface
REQ-001 SHALL have parameter READ_WAIT, default 1: extra SRAM read-access cycles per byte (legal range 0..7).
REQ-002 SHALL have port clk  input  1  system clock; all state changes on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port start  input  1  frame read request, sampled only in IDLE.
REQ-005 SHALL have port base_addr  input  20  SRAM address of first byte (R of pixel 0), latched on accepted start.
REQ-006 SHALL have port pixel_count  input  18  pixels to read, latched on accepted start.
REQ-007 SHALL have port pixel_r / pixel_g / pixel_b  output  8 each  assembled pixel.
REQ-008 SHALL have port pixel_valid  output  1  pixel outputs hold a valid pixel.
REQ-009 SHALL have port pixel_ready  input  1  consumer accepts the pixel when pixel_valid & pixel_ready.
REQ-010 SHALL have port busy  output  1  high in every state except IDLE.
REQ-011 SHALL have port done  output  1  one-cycle pulse at frame end.
REQ-012 SHALL have port overflow  output  1  sticky: frame truncated at address 20'hFFFFF; cleared on next accepted start.
REQ-013 SHALL have ports SRAM_ADDR (output, 20), SRAM_DQ (inout, 16), SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_LB_N, SRAM_UB_N (outputs, 1 each).

Function
REQ-014 SHALL implement states IDLE, READ, OUT, DONE.
REQ-015 IDLE: start=1 latches base_addr, pixel_count, clears overflow; next state READ with byte index 0; if pixel_count=0, next state DONE instead.
REQ-016 start in any state other than IDLE SHALL be ignored.
REQ-017 READ: SRAM_ADDR = current address; SRAM_CE_N=0, SRAM_OE_N=0, SRAM_LB_N=0; held for READ_WAIT+1 cycles per byte.
REQ-018 Last cycle of each byte: capture SRAM_DQ[7:0] into R (index 0), G (index 1), or B (index 2); increment address; advance index.
REQ-019 After index-2 capture, next state OUT; pixel outputs update from the captured bytes together, never partially.
REQ-020 OUT: pixel_valid=1, outputs stable until handshake; on pixel_valid & pixel_ready, decrement remaining count; next state READ if remaining>0, else DONE.
REQ-021 DONE: done=1 for exactly one cycle; next state IDLE.
REQ-022 Address increment SHALL saturate: if a byte is captured at 20'hFFFFF and further bytes remain, set overflow, abort the current partial pixel (no pixel_valid for it), go to DONE.
REQ-023 A pixel whose B byte is captured at 20'hFFFFF with remaining count 1 SHALL complete normally, without overflow.
REQ-024 SRAM_WE_N=1 and SRAM_UB_N=1 at all times; SRAM_DQ SHALL be high-impedance at all times.
REQ-025 Outside READ: SRAM_CE_N=1, SRAM_OE_N=1.
REQ-026 Timing with READ_WAIT=1: start sampled at edge of cycle 0; READ occupies cycles 1-6; pixel_valid first high in cycle 7.
REQ-027 Each pixel SHALL cost 3*(READ_WAIT+1) READ cycles plus at least 1 OUT cycle.
REQ-028 Back-pressure: pixel_ready=0 SHALL hold OUT indefinitely; no SRAM access during OUT.

Reset
REQ-029 rst=1 at a clock edge SHALL force IDLE from any state, including mid-READ and OUT.
REQ-030 Reset values: pixel_r/g/b=0, pixel_valid=0, busy=0, done=0, overflow=0, SRAM_ADDR=0, SRAM_CE_N=1, SRAM_OE_N=1, byte index=0, remaining count=0.
REQ-031 Reset SHALL take priority over start in the same cycle.

Verification
REQ-032 SRAM model holds 0x11,0x22,0x33 at 0x00100-0x00102; base=0x00100, count=1, ready=1 -> pixel (0x11,0x22,0x33) valid in cycle 7, done in cycle 9, busy low in cycle 10.
REQ-033 count=2, pixel_ready held 0 for 5 cycles after first valid -> first pixel stable 6 cycles, SRAM_OE_N=1 throughout, second pixel from addresses base+3..base+5.
REQ-034 base=0xFFFFE, count=2 -> no pixel_valid, overflow=1, done pulse; next start with base=0 clears overflow.
REQ-035 count=0 -> done pulse one cycle after start, pixel_valid never high, SRAM_CE_N stays 1.
REQ-036 rst asserted in cycle 4 of a READ -> next cycle IDLE, all outputs at reset values; start raised during busy is ignored.
REQ-037 READ_WAIT=0 and READ_WAIT=3 builds -> first pixel_valid in cycles 4 and 13 respectively.

Source files
------------

// File: rtl/sram_pixel_reader.sv
// rtl/sram_pixel_reader.sv - streams RGB888 pixels out of an async 16-bit SRAM, one byte per read
`timescale 1ns/1ps

module sram_pixel_reader #(
  parameter int READ_WAIT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [19:0] base_addr,
  input  logic [17:0] pixel_count,
  output logic [7:0]  pixel_r,
  output logic [7:0]  pixel_g,
  output logic [7:0]  pixel_b,
  output logic        pixel_valid,
  input  logic        pixel_ready,
  output logic        busy,
  output logic        done,
  output logic        overflow,
  output logic [19:0] SRAM_ADDR,
  inout  wire  [15:0] SRAM_DQ,
  output logic        SRAM_CE_N,
  output logic        SRAM_OE_N,
  output logic        SRAM_WE_N,
  output logic        SRAM_LB_N,
  output logic        SRAM_UB_N
);

  typedef enum logic [1:0] {IDLE, READ, OUT, DONE} state_t;

  localparam logic [2:0]  WAIT_LAST = 3'(READ_WAIT);
  localparam logic [19:0] ADDR_TOP  = 20'hFFFFF;

  state_t      state;
  state_t      next_state;
  logic [19:0] addr_q;
  logic [17:0] remaining_q;
  logic [1:0]  idx_q;
  logic [2:0]  wait_q;
  logic [7:0]  r_tmp;
  logic [7:0]  g_tmp;
  logic        valid_q;
  logic        overflow_q;

  logic [7:0]  dq_byte;
  logic        dq_hi_unused;
  logic        byte_last;
  logic        at_top;
  logic        ovf_hit;

  // The reader never writes, so the data bus is never driven; only the low lane is used.
  assign SRAM_DQ      = 16'hzzzz;
  assign dq_byte      = SRAM_DQ[7:0];
  assign dq_hi_unused = ^SRAM_DQ[15:8];

  // A byte is captured on the final access cycle; hitting the top address with
  // more bytes still owed truncates the frame (the final B byte of the frame may sit there).
  assign byte_last = (state == READ) && (wait_q == WAIT_LAST);
  assign at_top    = (addr_q == ADDR_TOP);
  assign ovf_hit   = byte_last && at_top && !((idx_q == 2'd2) && (remaining_q == 18'd1));

  assign SRAM_WE_N   = 1'b1;
  assign SRAM_UB_N   = 1'b1;
  assign SRAM_ADDR   = addr_q;
  assign pixel_valid = valid_q;
  assign overflow    = overflow_q;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Next-state decode and state-derived strobes; OUT lingers one cycle after the
  // handshake so the branch sees the already-decremented remaining count.
  always_comb begin
    next_state = state;
    busy       = 1'b0;
    done       = 1'b0;
    SRAM_CE_N  = 1'b1;
    SRAM_OE_N  = 1'b1;
    SRAM_LB_N  = 1'b1;
    case (state)
      IDLE: begin
        if (start) next_state = (pixel_count == 18'd0) ? DONE : READ;
      end
      READ: begin
        busy      = 1'b1;
        SRAM_CE_N = 1'b0;
        SRAM_OE_N = 1'b0;
        SRAM_LB_N = 1'b0;
        if (byte_last) begin
          if (ovf_hit)              next_state = DONE;
          else if (idx_q == 2'd2)   next_state = OUT;
        end
      end
      OUT: begin
        busy = 1'b1;
        if (!valid_q) next_state = (remaining_q != 18'd0) ? READ : DONE;
      end
      DONE: begin
        busy       = 1'b1;
        done       = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Datapath: frame latch, access timing, byte capture and pixel hand-off.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q      <= 20'd0;
      remaining_q <= 18'd0;
      idx_q       <= 2'd0;
      wait_q      <= 3'd0;
      r_tmp       <= 8'd0;
      g_tmp       <= 8'd0;
      pixel_r     <= 8'd0;
      pixel_g     <= 8'd0;
      pixel_b     <= 8'd0;
      valid_q     <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            addr_q      <= base_addr;
            remaining_q <= pixel_count;
            overflow_q  <= 1'b0;
            idx_q       <= 2'd0;
            wait_q      <= 3'd0;
          end
        end
        READ: begin
          if (byte_last) begin
            wait_q <= 3'd0;
            if (!at_top) addr_q <= addr_q + 20'd1;
            if (ovf_hit) begin
              overflow_q <= 1'b1;
              idx_q      <= 2'd0;
            end else if (idx_q == 2'd2) begin
              pixel_r <= r_tmp;
              pixel_g <= g_tmp;
              pixel_b <= dq_byte;
              valid_q <= 1'b1;
              idx_q   <= 2'd0;
            end else begin
              if (idx_q == 2'd0) r_tmp <= dq_byte;
              else               g_tmp <= dq_byte;
              idx_q <= idx_q + 2'd1;
            end
          end else begin
            wait_q <= wait_q + 3'd1;
          end
        end
        OUT: begin
          if (valid_q && pixel_ready) begin
            valid_q     <= 1'b0;
            remaining_q <= remaining_q - 18'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_pixel_reader.sv
// tb/tb_sram_pixel_reader.sv - bench for sram_pixel_reader against a frame-level pixel model
`timescale 1ns/1ps

module tb_sram_pixel_reader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start, pixel_ready;
  logic [19:0] base_addr;
  logic [17:0] pixel_count;

  logic [7:0]  m_r, m_g, m_b, a_r, a_g, a_b, c_r, c_g, c_b;
  logic        m_valid, m_busy, m_done, m_ovf, m_ce, m_oe, m_we, m_lb, m_ub;
  logic        a_valid, a_busy, a_done, a_ovf, a_ce, a_oe, a_we, a_lb, a_ub;
  logic        c_valid, c_busy, c_done, c_ovf, c_ce, c_oe, c_we, c_lb, c_ub;
  logic [19:0] m_addr, a_addr, c_addr;
  wire  [15:0] m_dq, a_dq, c_dq;

  function automatic logic [7:0] mem_byte(input logic [19:0] a);
    case (a)
      20'h00100: return 8'h11;
      20'h00101: return 8'h22;
      20'h00102: return 8'h33;
      default:   return a[7:0] ^ {a[11:8], a[15:12]} ^ {a[19:16], 4'hC} ^ 8'h5A;
    endcase
  endfunction

  // SRAM models: drive the bus only while the reader enables output.
  assign m_dq = (!m_oe) ? {8'hA5, mem_byte(m_addr)} : 16'hzzzz;
  assign a_dq = (!a_oe) ? {8'hA5, mem_byte(a_addr)} : 16'hzzzz;
  assign c_dq = (!c_oe) ? {8'hA5, mem_byte(c_addr)} : 16'hzzzz;

  sram_pixel_reader #(.READ_WAIT(1)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .pixel_count(pixel_count),
    .pixel_r(m_r), .pixel_g(m_g), .pixel_b(m_b), .pixel_valid(m_valid), .pixel_ready(pixel_ready),
    .busy(m_busy), .done(m_done), .overflow(m_ovf), .SRAM_ADDR(m_addr), .SRAM_DQ(m_dq),
    .SRAM_CE_N(m_ce), .SRAM_OE_N(m_oe), .SRAM_WE_N(m_we), .SRAM_LB_N(m_lb), .SRAM_UB_N(m_ub));

  sram_pixel_reader #(.READ_WAIT(0)) dut_w0 (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .pixel_count(pixel_count),
    .pixel_r(a_r), .pixel_g(a_g), .pixel_b(a_b), .pixel_valid(a_valid), .pixel_ready(pixel_ready),
    .busy(a_busy), .done(a_done), .overflow(a_ovf), .SRAM_ADDR(a_addr), .SRAM_DQ(a_dq),
    .SRAM_CE_N(a_ce), .SRAM_OE_N(a_oe), .SRAM_WE_N(a_we), .SRAM_LB_N(a_lb), .SRAM_UB_N(a_ub));

  sram_pixel_reader #(.READ_WAIT(3)) dut_w3 (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .pixel_count(pixel_count),
    .pixel_r(c_r), .pixel_g(c_g), .pixel_b(c_b), .pixel_valid(c_valid), .pixel_ready(pixel_ready),
    .busy(c_busy), .done(c_done), .overflow(c_ovf), .SRAM_ADDR(c_addr), .SRAM_DQ(c_dq),
    .SRAM_CE_N(c_ce), .SRAM_OE_N(c_oe), .SRAM_WE_N(c_we), .SRAM_LB_N(c_lb), .SRAM_UB_N(c_ub));

  typedef struct packed { logic [7:0] r; logic [7:0] g; logic [7:0] b; } pix_t;
  pix_t exp_q[$];
  logic exp_ovf = 1'b0;

  int   total = 0, bad = 0, cyc = 0, c0 = 0, done_rel = 0;
  int   hs_cnt = 0, ce_cnt = 0;
  logic chk_en = 1'b0, rand_ready = 1'b0;
  logic prev_hold = 1'b0;
  pix_t hold_pix;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Frame model: pixel i lives at base+3i..base+3i+2; a frame that would need a byte
  // past 0xFFFFF (or would capture 0xFFFFF with bytes still owed) is truncated.
  task automatic model_frame(input logic [19:0] b, input logic [17:0] n);
    longint ba;
    int cnt;
    cnt = int'(n);
    exp_ovf = 1'b0;
    for (int i = 0; i < cnt; i++) begin
      ba = longint'(b) + 3 * longint'(i);
      if ((ba + 2 > 64'hFFFFF) || ((ba + 2 == 64'hFFFFF) && (i < cnt - 1))) begin
        exp_ovf = 1'b1;
        break;
      end
      exp_q.push_back({mem_byte(20'(ba)), mem_byte(20'(ba + 1)), mem_byte(20'(ba + 2))});
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_frame(input logic [19:0] b, input logic [17:0] n);
    step();
    c0          = cyc;
    base_addr   = b;
    pixel_count = n;
    start       = 1'b1;
    model_frame(b, n);
    step();
    start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    logic got;
    got = 1'b0;
    for (int k = 0; k < 600; k++) begin
      @(negedge clk);
      if (m_done) begin
        got = 1'b1;
        break;
      end
    end
    done_rel = cyc - c0;
    chk(name, {31'd0, got}, 32'd1);
  endtask

  always @(posedge clk) begin
    #1;
    if (rand_ready) pixel_ready = ($urandom_range(0, 3) != 0);
  end

  // Per-cycle compare of the main instance against the frame model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("we_ub_high", {30'd0, m_we, m_ub}, 32'd3);
      chk("lb_oe_follow_ce", {30'd0, m_lb, m_oe}, {30'd0, m_ce, m_ce});
      if (!m_busy) chk("idle_no_access", {31'd0, m_ce}, 32'd1);
      if (m_valid) chk("out_no_access", {30'd0, m_ce, m_oe}, 32'd3);
      if (!m_ce) ce_cnt++;
      if (prev_hold)
        chk("pixel_stable", {7'd0, m_valid, m_r, m_g, m_b}, {8'd1, hold_pix});
      prev_hold = m_valid && !pixel_ready;
      hold_pix  = {m_r, m_g, m_b};
      if (m_valid && pixel_ready) begin
        hs_cnt++;
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL pixel_extra: got %0h expected none", {m_r, m_g, m_b});
        end else begin
          chk("pixel_data", {8'd0, m_r, m_g, m_b}, {8'd0, exp_q.pop_front()});
        end
      end
      if (m_done) begin
        chk("done_all_pixels", exp_q.size(), 32'd0);
        chk("done_overflow", {31'd0, m_ovf}, {31'd0, exp_ovf});
      end
    end else begin
      prev_hold = 1'b0;
    end
  end

  initial begin
    int   fv_m, fv_a, fv_c, dn, rel, h0, ce0, vcount, oe_bad;
    logic busy9, busy10, ce1, ce7, acc, got;
    logic [23:0] rgb7;
    logic [19:0] rb;
    logic [17:0] rn;

    rst = 1'b1; start = 1'b0; base_addr = 20'd0; pixel_count = 18'd0; pixel_ready = 1'b1;
    repeat (3) step();
    @(negedge clk);
    chk("rst_pixel", {8'd0, m_r, m_g, m_b}, 32'd0);
    chk("rst_flags", {28'd0, m_valid, m_busy, m_done, m_ovf}, 32'd0);
    chk("rst_addr", {12'd0, m_addr}, 32'd0);
    chk("rst_ce_oe", {30'd0, m_ce, m_oe}, 32'd3);
    step();
    rst = 1'b0;
    chk_en = 1'b1;

    // Single pixel at 0x100 on all three builds: latency and literal data.
    fv_m = 99; fv_a = 99; fv_c = 99; dn = 99;
    busy9 = 1'b0; busy10 = 1'b1; ce1 = 1'b1; ce7 = 1'b0; rgb7 = 24'd0;
    start_frame(20'h00100, 18'd1);
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      rel = cyc - c0;
      if (m_valid && fv_m == 99) begin fv_m = rel; rgb7 = {m_r, m_g, m_b}; end
      if (a_valid && fv_a == 99) fv_a = rel;
      if (c_valid && fv_c == 99) fv_c = rel;
      if (m_done && dn == 99) dn = rel;
      if (rel == 1)  ce1 = m_ce;
      if (rel == 7)  ce7 = m_ce;
      if (rel == 9)  busy9 = m_busy;
      if (rel == 10) busy10 = m_busy;
    end
    chk("first_valid_w1", fv_m, 32'd7);
    chk("first_pixel_w1", {8'd0, rgb7}, 32'h00112233);
    chk("done_cycle_w1", dn, 32'd9);
    chk("busy_c9_c10", {30'd0, busy9, busy10}, 32'd2);
    chk("ce_c1_c7", {30'd0, ce1, ce7}, 32'd1);
    chk("first_valid_w0", fv_a, 32'd4);
    chk("first_valid_w3", fv_c, 32'd13);

    // Back-pressure: ready low for five cycles from the first valid.
    vcount = 0; oe_bad = 0; acc = 1'b0; got = 1'b0;
    start_frame(20'h00200, 18'd2);
    for (int k = 1; k <= 60 && !got; k++) begin
      pixel_ready = (k < 7) || (k > 11);
      @(negedge clk);
      if (m_valid && !acc) begin
        vcount++;
        if (!m_oe) oe_bad++;
        if (pixel_ready) acc = 1'b1;
      end
      if (m_done) got = 1'b1;
      else        step();
    end
    pixel_ready = 1'b1;
    chk("bp_valid_cycles", vcount, 32'd6);
    chk("bp_oe_during_out", oe_bad, 32'd0);
    chk("bp_done", {31'd0, got}, 32'd1);

    // Address saturation.
    h0 = hs_cnt;
    start_frame(20'hFFFFE, 18'd2);
    wait_done("ovf_done");
    chk("ovf_no_pixel", hs_cnt - h0, 32'd0);
    chk("ovf_set", {31'd0, m_ovf}, 32'd1);
    start_frame(20'h00000, 18'd1);
    @(negedge clk);
    chk("ovf_cleared", {31'd0, m_ovf}, 32'd0);
    wait_done("ovf_clear_done");
    h0 = hs_cnt;
    start_frame(20'hFFFFD, 18'd1);
    wait_done("top_pixel_done");
    chk("top_pixel_count", hs_cnt - h0, 32'd1);
    chk("top_pixel_no_ovf", {31'd0, m_ovf}, 32'd0);
    h0 = hs_cnt;
    start_frame(20'hFFFFA, 18'd3);
    wait_done("top_trunc_done");
    chk("top_trunc_count", hs_cnt - h0, 32'd1);
    chk("top_trunc_ovf", {31'd0, m_ovf}, 32'd1);

    // Empty frame.
    h0 = hs_cnt; ce0 = ce_cnt;
    start_frame(20'h00123, 18'd0);
    wait_done("zero_done");
    chk("zero_done_cycle", done_rel, 32'd1);
    chk("zero_no_access", ce_cnt - ce0, 32'd0);
    chk("zero_no_pixel", hs_cnt - h0, 32'd0);

    // Start while busy is ignored.
    h0 = hs_cnt;
    start_frame(20'h00300, 18'd1);
    step(); step();
    base_addr = 20'h05000; pixel_count = 18'd3; start = 1'b1;
    step();
    start = 1'b0;
    wait_done("busy_start_done");
    chk("busy_start_ignored", hs_cnt - h0, 32'd1);

    // Reset in cycle 4 of a READ.
    start_frame(20'h00400, 18'd5);
    step(); step(); step();
    chk_en = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("mid_read_active", {31'd0, m_ce}, 32'd0);
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_pixel", {8'd0, m_r, m_g, m_b}, 32'd0);
    chk("midrst_flags", {28'd0, m_valid, m_busy, m_done, m_ovf}, 32'd0);
    chk("midrst_addr", {12'd0, m_addr}, 32'd0);
    chk("midrst_ce_oe", {30'd0, m_ce, m_oe}, 32'd3);
    exp_q.delete();

    // Reset wins over start in the same cycle.
    step();
    rst = 1'b1; start = 1'b1; base_addr = 20'h00100; pixel_count = 18'd1;
    step();
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
    chk("rst_over_start", {30'd0, m_busy, m_ce}, 32'd1);
    chk_en = 1'b1;

    // Random frames with random back-pressure.
    rand_ready = 1'b1;
    for (int f = 0; f < 30; f++) begin
      if ($urandom_range(0, 3) == 0) rb = 20'hFFFFF - 20'($urandom_range(0, 20));
      else                           rb = 20'($urandom);
      rn = 18'($urandom_range(0, 6));
      start_frame(rb, rn);
      wait_done("rand_done");
    end
    rand_ready = 1'b0;
    pixel_ready = 1'b1;
    step();
    chk("model_drained", exp_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
